// File: rtl/exec_unit.sv
// Execution unit: single-cycle add/sub ALU with NZCV flags, plus a sequential
// 3x3 convolution kernel (one signed MAC per cycle, then a clamp step).
module exec_unit #(
  parameter int BUS = 16,
  parameter int PIX = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BUS-1:0]            opa,
  input  logic [BUS-1:0]            opb,
  input  logic [1:0]                funtype,
  input  logic [1:0]                funcode,
  input  logic [1:0]                kernelsel,
  input  logic [2:0][3*PIX-1:0]     window,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BUS-1:0]            result,
  output logic [3:0]                cpsr
);

  localparam int ACCW = 2*PIX + 5;
  localparam logic signed [ACCW-1:0] PMAX = ACCW'((1 << PIX) - 1);

  typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;

  state_t                 state_q, state_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [3:0]             tap_q, tap_d;
  logic [1:0]             ksel_q, ksel_d;
  logic [PIX-1:0]         pix_q [9];
  logic [PIX-1:0]         pix_d [9];
  logic                   out_valid_q, out_valid_d;
  logic [BUS-1:0]         result_q, result_d;
  logic [3:0]             cpsr_q, cpsr_d;

  logic                   accept, consume;
  logic                   alu_sub, alu_v;
  logic [BUS-1:0]         opb_eff;
  logic [BUS:0]           alu_sum;
  logic [PIX-1:0]         cur_pix;
  logic signed [4:0]      coef;
  logic signed [ACCW-1:0] pix_ext, coef_ext, prod, scaled;
  logic [PIX-1:0]         sat_pix;
  logic                   clamped;

  // Row-major 3x3 coefficient sets; taps 1,3,5,7 are the edge-adjacent ones.
  function automatic logic signed [4:0] coef_f(input logic [1:0] ks, input logic [3:0] t);
    logic signed [4:0] c;
    c = '0;
    case (ks)
      2'b00:   c = (t == 4'd4) ? 5'sd1 : 5'sd0;
      2'b01:   c = (t == 4'd4) ? 5'sd5 : (t[0] ? -5'sd1 : 5'sd0);
      2'b10:   c = (t == 4'd4) ? 5'sd8 : -5'sd1;
      default: c = (t == 4'd4) ? 5'sd4 : (t[0] ? 5'sd2 : 5'sd1);
    endcase
    return c;
  endfunction

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cpsr      = cpsr_q;

  always_comb begin
    alu_sub = funcode[0];
    opb_eff = alu_sub ? ~opb : opb;
    alu_sum = {1'b0, opa} + {1'b0, opb_eff} + {{BUS{1'b0}}, alu_sub};
    alu_v   = (opa[BUS-1] == opb_eff[BUS-1]) && (alu_sum[BUS-1] != opa[BUS-1]);
  end

  always_comb begin
    cur_pix  = pix_q[tap_q];
    coef     = coef_f(ksel_q, tap_q);
    pix_ext  = {{(ACCW-PIX){1'b0}}, cur_pix};
    coef_ext = {{(ACCW-5){coef[4]}}, coef};
    prod     = pix_ext * coef_ext;
    scaled   = (ksel_q == 2'b11) ? (acc_q >>> 4) : acc_q;
    sat_pix  = scaled[PIX-1:0];
    clamped  = 1'b0;
    if (scaled[ACCW-1]) begin
      sat_pix = '0;
      clamped = 1'b1;
    end else if (scaled > PMAX) begin
      sat_pix = '1;
      clamped = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    tap_d       = tap_q;
    ksel_d      = ksel_q;
    pix_d       = pix_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    cpsr_d      = cpsr_q;
    if (consume) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (funtype == 2'b11) begin
            state_d = MAC;
            acc_d   = '0;
            tap_d   = '0;
            ksel_d  = kernelsel;
            for (int unsigned r = 0; r < 3; r++)
              for (int unsigned c = 0; c < 3; c++)
                pix_d[r*3 + c] = window[r][PIX*c +: PIX];
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_sum[BUS-1:0];
            cpsr_d      = {alu_sum[BUS-1], alu_sum[BUS-1:0] == '0, alu_sum[BUS], alu_v};
          end
        end
      end
      MAC: begin
        if (flush) begin
          state_d = IDLE;
          acc_d   = '0;
          tap_d   = '0;
        end else begin
          acc_d = acc_q + prod;
          if (tap_q == 4'd8) begin
            state_d = SAT;
            tap_d   = '0;
          end else begin
            tap_d = tap_q + 4'd1;
          end
        end
      end
      SAT: begin
        state_d = IDLE;
        acc_d   = '0;
        if (!flush) begin
          out_valid_d = 1'b1;
          result_d    = {{(BUS-PIX){1'b0}}, sat_pix};
          cpsr_d      = {1'b0, sat_pix == '0, clamped, 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      tap_q       <= '0;
      ksel_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cpsr_q      <= '0;
      for (int unsigned i = 0; i < 9; i++) pix_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tap_q       <= tap_d;
      ksel_q      <= ksel_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cpsr_q      <= cpsr_d;
      pix_q       <= pix_d;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: transaction-level reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_exec_unit;
  localparam int BUS = 16;
  localparam int PIX = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       opa = '0, opb = '0;
  logic [1:0]        funtype = '0, funcode = '0, kernelsel = '0;
  logic [2:0][23:0]  window = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [15:0]       result;
  logic [3:0]        cpsr;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  exec_unit #(.BUS(BUS), .PIX(PIX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opa(opa), .opb(opb), .funtype(funtype), .funcode(funcode),
    .kernelsel(kernelsel), .window(window), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cpsr(cpsr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int coefs [4][9] = '{'{0, 0, 0, 0, 1, 0, 0, 0, 0},
                       '{0,-1, 0,-1, 5,-1, 0,-1, 0},
                       '{-1,-1,-1,-1, 8,-1,-1,-1,-1},
                       '{1, 2, 1, 2, 4, 2, 1, 2, 1}};

  function automatic logic [19:0] alu_ref(input logic [1:0] fc, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        c, v;
    int          sr;
    if (fc[0]) begin
      r  = a - b;
      c  = (a >= b);
      sr = int'($signed(a)) - int'($signed(b));
    end else begin
      r  = a + b;
      c  = ((32'(a) + 32'(b)) > 32'hFFFF);
      sr = int'($signed(a)) + int'($signed(b));
    end
    v = (sr > 32767) || (sr < -32768);
    return {r[15], r == 16'h0, c, v, r};
  endfunction

  function automatic logic [19:0] kern_ref(input logic [1:0] ks, input logic [2:0][23:0] w);
    int         s, px;
    logic [7:0] r8;
    logic       c;
    s = 0;
    for (int t = 0; t < 9; t++) begin
      px = int'(w[t/3][8*(t%3) +: 8]);
      s  = s + coefs[ks][t] * px;
    end
    if (ks == 2'b11) s = s >>> 4;
    if (s < 0) begin r8 = 8'h00; c = 1'b1; end
    else if (s > 255) begin r8 = 8'hFF; c = 1'b1; end
    else begin r8 = 8'(s); c = 1'b0; end
    return {1'b0, r8 == 8'h00, c, 1'b0, 8'h00, r8};
  endfunction

  logic        m_valid = 1'b0;
  logic [15:0] m_result = '0, p_result = '0;
  logic [3:0]  m_cpsr = '0, p_cpsr = '0;
  int          m_busy = 0;
  logic        m_ready, m_acc, m_cons;

  assign m_ready = (m_busy == 0) && (!m_valid || out_ready);
  assign m_acc   = m_ready && in_valid;
  assign m_cons  = m_valid && out_ready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_result <= '0;
      m_cpsr   <= '0;
      m_busy   <= 0;
    end else if (m_busy > 0) begin
      if (flush) m_busy <= 0;
      else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_valid  <= 1'b1;
          m_result <= p_result;
          m_cpsr   <= p_cpsr;
        end
      end
    end else if (m_acc) begin
      if (funtype == 2'b11) begin
        m_busy <= 10;
        {p_cpsr, p_result} <= kern_ref(kernelsel, window);
        if (m_cons) m_valid <= 1'b0;
      end else begin
        m_valid <= 1'b1;
        {m_cpsr, m_result} <= alu_ref(funcode, opa, opb);
      end
    end else if (m_cons) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, m_valid);
    chk("in_ready", in_ready, m_ready);
    chk("result", result, m_result);
    chk("cpsr", cpsr, m_cpsr);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0][23:0] mkwin(input logic [7:0] ctr, input logic [7:0] oth);
    logic [2:0][23:0] w;
    w = {9{oth}};
    w[1][15:8] = ctr;
    return w;
  endfunction

  task automatic send(input logic [1:0] ft, input logic [1:0] fc, input logic [1:0] ks,
                      input logic [15:0] a, input logic [15:0] b, input logic [2:0][23:0] w);
    int k;
    k = 0;
    funtype = ft; funcode = fc; kernelsel = ks; opa = a; opb = b; window = w;
    in_valid = 1'b1;
    #1;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) chk("send_timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic alu(input string nm, input logic [1:0] fc, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] er, input logic [3:0] ec);
    send(2'b00, fc, 2'b00, a, b, '0);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_res"}, result, er);
    chk({nm, "_cpsr"}, cpsr, ec);
  endtask

  task automatic kern(input string nm, input logic [1:0] ks, input logic [2:0][23:0] w,
                      input logic [15:0] er, input logic [3:0] ec);
    send(2'b11, 2'b00, ks, 16'hA5A5, 16'h5A5A, w);
    window = mkwin(8'h3C, 8'hC3);  // post-accept input changes must be ignored
    kernelsel = ~ks;
    opa = 16'hFFFF;
    repeat (9) step();
    chk({nm, "_early"}, out_valid, 0);
    step();
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_res"}, result, er);
    chk({nm, "_cpsr"}, cpsr, ec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errs %0d", errs);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) step();
    chk("rst_res", result, 16'h0000);
    chk("rst_cpsr", cpsr, 4'h0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;
    step();

    alu("add_ovf", 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001);
    alu("cmp_eq", 2'b11, 16'h0005, 16'h0005, 16'h0000, 4'b0110);
    alu("sub_neg", 2'b01, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000);
    alu("mov", 2'b10, 16'h0000, 16'h1234, 16'h1234, 4'b0000);
    alu("sub_ovf", 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011);
    alu("add_carry", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110);

    kern("sharpen200", 2'b01, mkwin(8'd200, 8'd200), 16'h00C8, 4'b0000);
    kern("edge_hi", 2'b10, mkwin(8'd255, 8'd0), 16'h00FF, 4'b0010);
    kern("edge_lo", 2'b10, mkwin(8'd0, 8'd255), 16'h0000, 4'b0110);
    kern("ident", 2'b00, mkwin(8'd77, 8'd200), 16'h004D, 4'b0000);

    // gaussian result held under backpressure, next op accepted as out_ready rises
    send(2'b11, 2'b00, 2'b11, 16'h0, 16'h0, mkwin(8'd16, 8'd16));
    out_ready = 1'b0;
    repeat (10) step();
    chk("gauss_valid", out_valid, 1);
    chk("gauss_res", result, 16'h0010);
    funtype = 2'b00; funcode = 2'b00; opa = 16'd2; opb = 16'd3; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_ready", in_ready, 0);
      chk("hold_res", result, 16'h0010);
      chk("hold_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("rise_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("reload_valid", out_valid, 1);
    chk("reload_res", result, 16'h0005);
    chk("reload_cpsr", cpsr, 4'b0000);

    // flush during MAC tap 6
    alu("pre_flush", 2'b01, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000);
    send(2'b11, 2'b00, 2'b01, 16'h0, 16'h0, mkwin(8'd200, 8'd200));
    repeat (6) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idle", in_ready, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_res", result, 16'hFFFE);
    chk("flush_cpsr", cpsr, 4'b1000);
    repeat (12) step();
    chk("flush_none", out_valid, 0);
    kern("after_flush", 2'b00, mkwin(8'd9, 8'd200), 16'h0009, 4'b0000);

    // flush during SAT
    send(2'b11, 2'b00, 2'b10, 16'h0, 16'h0, mkwin(8'd255, 8'd0));
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("satfl_valid", out_valid, 0);
    chk("satfl_res", result, 16'h0009);
    repeat (12) step();
    chk("satfl_none", out_valid, 0);

    // flush in IDLE is ignored; the op is accepted
    flush = 1'b1;
    alu("idle_flush", 2'b00, 16'h0001, 16'h0002, 16'h0003, 4'b0000);
    flush = 1'b0;

    // reset at MAC tap 4
    send(2'b11, 2'b00, 2'b01, 16'h0, 16'h0, mkwin(8'd200, 8'd200));
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("midrst_res", result, 16'h0000);
    chk("midrst_cpsr", cpsr, 4'h0);
    chk("midrst_valid", out_valid, 0);
    repeat (2) step();
    rst = 1'b0;
    chk("postrst_ready", in_ready, 1);
    alu("post_rst", 2'b00, 16'h0001, 16'h0001, 16'h0002, 4'b0000);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
